// File: rtl/pixel_window.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a shifting
// 3x3 window register, with border windows suppressed via win_valid.
module pixel_window #(
   parameter int WIDTH  = 64,
   parameter int HEIGHT = 48
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sof,
   input  logic        pix_valid,
   input  logic [7:0]  pix_in,
   output logic        win_valid,
   output logic [71:0] win,
   output logic        frame_done
);

   localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   logic [CW-1:0] col, cur_col;
   logic [RW-1:0] row, cur_row;
   logic [7:0]    lb0 [WIDTH];
   logic [7:0]    lb1 [WIDTH];
   logic [7:0]    lb0_rd, lb1_rd;
   logic          last_col, last_row;

   // sof relocates the accompanying pixel to (0,0) before anything uses the position
   always_comb begin
      cur_col  = sof ? '0 : col;
      cur_row  = sof ? '0 : row;
      lb0_rd   = lb0[cur_col];
      lb1_rd   = lb1[cur_col];
      last_col = (cur_col == CW'(WIDTH - 1));
      last_row = (cur_row == RW'(HEIGHT - 1));
   end

   always_ff @(posedge clk) begin
      if (pix_valid) begin
         lb1[cur_col] <= lb0_rd;
         lb0[cur_col] <= pix_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col        <= '0;
         row        <= '0;
         win        <= '0;
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
         if (pix_valid) begin
            // each row of three bytes shifts left; the new right column enters
            win       <= {win[63:48], lb1_rd, win[39:24], lb0_rd, win[15:0], pix_in};
            win_valid <= (cur_row >= RW'(2)) && (cur_col >= CW'(2));
            if (last_col) begin
               col <= '0;
               if (last_row) begin
                  row        <= '0;
                  frame_done <= !sof;
               end else begin
                  row <= cur_row + 1'b1;
               end
            end else begin
               col <= cur_col + 1'b1;
               row <= cur_row;
            end
         end else if (sof) begin
            col <= '0;
            row <= '0;
         end
      end
   end

endmodule

// File: doc/pixel_window.md
# pixel_window

Streaming 3x3 neighbourhood generator that sits directly upstream of the `Edge` filter. It accepts one 8-bit pixel per `pix_valid` strobe in raster order, for example from the SPI receive path's `done`/`dout`. Two internal line buffers hold the previous rows, so each accepted pixel produces a full 3x3 window with the current pixel at bottom-right. The filter consumes the window with a single-cycle valid strobe; border positions without a complete neighbourhood are suppressed.

## Interface
- `WIDTH`, default 64: pixels per line, legal range 3..1024.
- `HEIGHT`, default 48: lines per frame, legal range 3..1024.
- `clk` input 1: system clock (50 MHz domain).
- `rst_n` input 1: reset, asynchronous, active-low.
- `sof` input 1: start of frame; resets the position counters.
- `pix_valid` input 1: one-cycle strobe marking `pix_in` as valid.
- `pix_in` input 8: incoming pixel.
- `win_valid` output 1: one-cycle strobe marking `win` as a complete window.
- `win` output 72: window, nine bytes packed row-major, oldest first.
  - `win[71:64]` = (r-2, c-2).
  - `win[7:0]` = (r, c), the current pixel.
- `frame_done` output 1: one-cycle pulse after the last pixel of a frame.

## Operation
- Position counters:
  - `col` is 0..WIDTH-1; `row` is 0..HEIGHT-1.
  - Both advance only on `pix_valid`.
  - When `col` reaches WIDTH-1 it wraps to 0 and `row` increments.
  - At (HEIGHT-1, WIDTH-1), both counters wrap to 0 and `frame_done` pulses.
- Line buffers:
  - Two WIDTH x 8 arrays: `lb0` holds row r-1, `lb1` holds row r-2.
  - On `pix_valid`: `lb1[col] <= lb0[col]` and `lb0[col] <= pix_in`; read-before-write at the same address.
  - Contents are not cleared by reset or `sof`; stale data is never exposed because of `win_valid` gating.
- Window register:
  - Three columns of three pixels.
  - On `pix_valid`, the columns shift left; the new right column is {`lb1[col]`, `lb0[col]`, `pix_in`} (top, mid, bottom).
  - The shift happens at every position, including borders and line wrap.
- Valid rule: `win_valid` is asserted for an accepted pixel when that pixel's `row >= 2` and `col >= 2`.
  - Windows never span a line wrap, because `col >= 2` is required.
  - Valid windows per frame: (WIDTH-2)*(HEIGHT-2).
- `sof` handling:
  - `sof` without `pix_valid`: counters go to 0 and nothing else changes.
  - `sof` with `pix_valid`: the pixel is taken as (0,0) and the counters advance to (0,1).
  - `sof` takes priority over wrap and over a pending `frame_done`; no `frame_done` is generated for an aborted frame.
- Gaps of any length between `pix_valid` strobes are allowed; all state holds.
- Back-to-back `pix_valid` on every cycle is supported; there is no backpressure.

## Timing
- Reset values:
  - `win_valid` = 0, `frame_done` = 0, `win` = 72'h0.
  - Counters = 0, window register = 0.
- Latency:
  - `win` and `win_valid` update on the clock edge that samples `pix_valid`, so they are visible in the cycle after the strobe.
  - `win_valid` is a 1-cycle pulse.
  - `win` holds its value until the next `pix_valid`.
- `frame_done` is asserted in the same cycle as the `win_valid` for the (HEIGHT-1, WIDTH-1) pixel.
- Throughput is 1 pixel per clock.
- Line buffer read must be combinational or otherwise complete within the accepting cycle, so latency stays at one clock.
- Asynchronous `rst_n` mid-frame: all outputs drop immediately. The next frame starts at (0,0) without needing `sof`.

## Test plan
All scenarios use WIDTH=4, HEIGHT=4 and pixel value p(r,c) = 4r+c.

- Single frame, continuous `pix_valid` after reset:
  - Exactly 4 `win_valid` pulses, at pixels 10, 11, 14 and 15.
  - First window = 72'h00_01_02_04_05_06_08_09_0A.
  - Last window = 72'h05_06_07_09_0A_0B_0D_0E_0F.
  - `frame_done` is asserted with the final window only.
- Same frame with random 0-5 idle cycles between strobes: identical window sequence; no `win_valid` during gaps.
- Two frames back-to-back without `sof`, with the second frame's pixels being p+0x40:
  - Second-frame first window = 72'h40_41_42_44_45_46_48_49_4A.
  - Total of 8 valid windows and 2 `frame_done` pulses.
- `sof` asserted with the pixel at (2,1) of frame 1, then a full frame:
  - Counters restart and that pixel counts as (0,0).
  - The following 15 pixels yield valid windows at stream positions 10, 11, 14 and 15.
  - No `frame_done` for the aborted frame.
- `rst_n` pulsed low mid-row 3:
  - `win_valid`, `frame_done` and `win` go to 0 asynchronously.
  - The next 16 pixels produce the first-scenario results exactly.
